// File: rtl/muxn_rr_reg.sv
// Registered N-to-1 multiplexer with per-channel valid/ready handshakes.
// MODE=0 picks the channel named by selector; MODE=1 arbitrates round-robin among valid channels.
module muxn_rr_reg #(
  parameter int BUS_WIDTH = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_WIDTH = 2,
  parameter int MODE      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEL_WIDTH-1:0]        selector,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN*BUS_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]        out_sel
);

  logic [NUM_IN-1:0]    grant;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 can_load;
  logic                 load;

  logic                 out_valid_reg;
  logic [BUS_WIDTH-1:0] out_data_reg;
  logic [BUS_WIDTH-1:0] out_data_next;
  logic [SEL_WIDTH-1:0] out_sel_reg;

  // The single-entry output register accepts a word when empty or draining this cycle.
  assign can_load = !out_valid_reg || out_ready;
  assign load     = (|grant) && can_load;
  assign in_ready = grant & {NUM_IN{can_load}};

  generate
    if (MODE == 0) begin : g_select
      genvar gi;
      // Out-of-range selector values match no channel, so grant stays zero.
      for (gi = 0; gi < NUM_IN; gi++) begin : g_grant
        assign grant[gi] = rst_n && in_valid[gi] && (selector == SEL_WIDTH'(gi));
      end
      assign grant_idx = selector;
    end else begin : g_round_robin
      logic [SEL_WIDTH-1:0] ptr_reg;

      // Scan starts just after the last channel served, wrapping once around.
      always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
          idx = (int'(ptr_reg) + k) % NUM_IN;
          if (!found && in_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = SEL_WIDTH'(idx);
            found      = 1'b1;
          end
        end
        if (!rst_n) begin
          grant = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ptr_reg <= SEL_WIDTH'(NUM_IN - 1);
        end else if (load) begin
          ptr_reg <= grant_idx;
        end
      end
    end
  endgenerate

  // Grant is one-hot or zero, so an AND-OR reduction selects the granted channel.
  logic [BUS_WIDTH-1:0] ch_masked [NUM_IN];

  generate
    genvar gi;
    for (gi = 0; gi < NUM_IN; gi++) begin : g_mask
      assign ch_masked[gi] = in_data[gi*BUS_WIDTH +: BUS_WIDTH] & {BUS_WIDTH{grant[gi]}};
    end
  endgenerate

  always_comb begin
    out_data_next = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      out_data_next = out_data_next | ch_masked[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= grant_idx;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Bench for muxn_rr_reg: one selector-mode and one round-robin instance checked every
// cycle against a behavioural model, plus directed vectors with literal expectations.
module tb_muxn_rr_reg;
  localparam int BW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [2:0]      sel0;
  logic [N-1:0]    iv0, rdy0;
  logic [N*BW-1:0] id0;
  logic            ov0, ordy0;
  logic [BW-1:0]   od0;
  logic [2:0]      os0;

  logic [1:0]      sel1;
  logic [N-1:0]    iv1, rdy1;
  logic [N*BW-1:0] id1;
  logic            ov1, ordy1;
  logic [BW-1:0]   od1;
  logic [1:0]      os1;

  muxn_rr_reg #(.BUS_WIDTH(BW), .NUM_IN(N), .SEL_WIDTH(3), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .selector(sel0), .in_valid(iv0), .in_data(id0),
    .in_ready(rdy0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_sel(os0)
  );

  muxn_rr_reg #(.BUS_WIDTH(BW), .NUM_IN(N), .SEL_WIDTH(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .selector(sel1), .in_valid(iv1), .in_data(id1),
    .in_ready(rdy1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_sel(os1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: what each output register must hold, and the last channel served.
  logic            e_v   [2];
  logic [BW-1:0]   e_d   [2];
  int              e_s   [2];
  int              e_ptr [2];
  bit              live = 1'b0;

  function automatic int model_grant(input int mode, input int ptr, input logic [N-1:0] v,
                                     input int s);
    if (!rst_n) return -1;
    if (mode == 0) begin
      if (s >= N) return -1;
      return v[s] ? s : -1;
    end
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int g, input logic v, input logic r);
    logic [N-1:0] res;
    res = '0;
    if (g >= 0 && (!v || r)) res[g] = 1'b1;
    return res;
  endfunction

  task automatic step(input int m, input int g, input logic r, input logic [N*BW-1:0] d);
    if (!rst_n) begin
      e_v[m] = 1'b0; e_d[m] = '0; e_s[m] = 0; e_ptr[m] = N - 1;
    end else if (g >= 0 && (!e_v[m] || r)) begin
      e_v[m] = 1'b1; e_d[m] = d[g*BW +: BW]; e_s[m] = g; e_ptr[m] = g;
    end else if (e_v[m] && r) begin
      e_v[m] = 1'b0;
    end
  endtask

  // Compare on the falling edge, then advance the model by the coming rising edge.
  always @(negedge clk) begin
    int g0, g1;
    g0 = model_grant(0, e_ptr[0], iv0, int'(sel0));
    g1 = model_grant(1, e_ptr[1], iv1, int'(sel1));
    if (live) begin
      chk("m0.out_valid", 64'(ov0),  64'(e_v[0]));
      chk("m0.out_data",  64'(od0),  64'(e_d[0]));
      chk("m0.out_sel",   64'(os0),  64'(e_s[0]));
      chk("m0.in_ready",  64'(rdy0), 64'(exp_ready(g0, e_v[0], ordy0)));
      chk("m1.out_valid", 64'(ov1),  64'(e_v[1]));
      chk("m1.out_data",  64'(od1),  64'(e_d[1]));
      chk("m1.out_sel",   64'(os1),  64'(e_s[1]));
      chk("m1.in_ready",  64'(rdy1), 64'(exp_ready(g1, e_v[1], ordy1)));
    end
    step(0, g0, ordy0, id0);
    step(1, g1, ordy1, id1);
    if (!rst_n) live = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sel0 = 3'd0; iv0 = 4'hF; ordy0 = 1'b1; id0 = '0;
    sel1 = 2'd0; iv1 = 4'hF; ordy1 = 1'b1;
    for (int i = 0; i < N; i++) id1[i*BW +: BW] = BW'(i);

    // Reset held two cycles with every channel valid
    tick(); tick();
    chk("rst.m0.out_valid", 64'(ov0), 64'd0);
    chk("rst.m0.out_data",  64'(od0), 64'd0);
    chk("rst.m0.out_sel",   64'(os0), 64'd0);
    chk("rst.m0.in_ready",  64'(rdy0), 64'd0);
    chk("rst.m1.out_valid", 64'(ov1), 64'd0);
    chk("rst.m1.in_ready",  64'(rdy1), 64'd0);
    rst_n = 1'b1; iv0 = 4'h0;
    #1 chk("rr.first_grant", 64'(rdy1), 64'b0001);

    // Round-robin fairness: sequence 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr.fair.valid", 64'(ov1), 64'd1);
      chk("rr.fair.sel",   64'(os1), 64'(k % N));
      chk("rr.fair.data",  64'(od1), 64'(k % N));
    end

    // Skip/wrap: serve ch2, idle two cycles, then 0011 -> 0,1,0
    iv1 = 4'b0100;
    tick(); chk("rr.ch2.sel", 64'(os1), 64'd2);
    iv1 = 4'b0000;
    tick(); chk("rr.idle.valid", 64'(ov1), 64'd0);
    tick();
    iv1 = 4'b0011;
    #1 chk("rr.wrap.ready", 64'(rdy1), 64'b0001);
    tick(); chk("rr.wrap.sel_a", 64'(os1), 64'd0);
    tick(); chk("rr.wrap.sel_b", 64'(os1), 64'd1);
    tick(); chk("rr.wrap.sel_c", 64'(os1), 64'd0);

    // Reset during a stall
    ordy1 = 1'b0; iv1 = 4'hF;
    #1 chk("rr.stall.ready", 64'(rdy1), 64'd0);
    tick(); chk("rr.stall.valid", 64'(ov1), 64'd1);
    rst_n = 1'b0;
    tick(); chk("rr.midrst.valid", 64'(ov1), 64'd0);
    chk("rr.midrst.sel", 64'(os1), 64'd0);
    rst_n = 1'b1; ordy1 = 1'b1;
    #1 chk("rr.midrst.ptr", 64'(rdy1), 64'b0001);
    tick(); chk("rr.after.sel", 64'(os1), 64'd0);
    iv1 = 4'h0;
    tick(); chk("rr.after.drain", 64'(ov1), 64'd0);

    // Selector mode: ch2 via selector, then out-of-range selector 5
    sel0 = 3'd2; iv0 = 4'b0100; id0[2*BW +: BW] = 32'hDEADBEEF;
    #1 chk("sel.ready", 64'(rdy0), 64'b0100);
    tick();
    chk("sel.valid", 64'(ov0), 64'd1);
    chk("sel.data",  64'(od0), 64'hDEADBEEF);
    chk("sel.sel",   64'(os0), 64'd2);
    sel0 = 3'd5;
    #1 chk("sel.oor.ready", 64'(rdy0), 64'd0);
    tick();
    chk("sel.oor.valid", 64'(ov0), 64'd0);
    chk("sel.oor.data",  64'(od0), 64'hDEADBEEF);

    // Back-pressure: hold ch1 word three cycles, then load ch3 with no bubble
    sel0 = 3'd1; iv0 = 4'b0010; id0[1*BW +: BW] = 32'h11;
    tick(); chk("bp.load", 64'(od0), 64'h11);
    ordy0 = 1'b0; iv0 = 4'hF; sel0 = 3'd3; id0[3*BW +: BW] = 32'h33333333;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp.ready", 64'(rdy0), 64'd0);
      tick();
      chk("bp.hold.data",  64'(od0), 64'h11);
      chk("bp.hold.valid", 64'(ov0), 64'd1);
    end
    ordy0 = 1'b1;
    #1 chk("bp.release.ready", 64'(rdy0), 64'b1000);
    tick();
    chk("bp.next.valid", 64'(ov0), 64'd1);
    chk("bp.next.data",  64'(od0), 64'h33333333);
    chk("bp.next.sel",   64'(os0), 64'd3);
    iv0 = 4'h0;
    tick(); chk("bp.drain", 64'(ov0), 64'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
